// File: rtl/sdram_burst_pkg.sv
// Shared SDRAM burst definitions: BL codes, address modes, FSM encoding, burst mask helpers.
package sdram_burst_pkg;

    localparam logic [2:0] BL_1    = 3'd0;
    localparam logic [2:0] BL_2    = 3'd1;
    localparam logic [2:0] BL_4    = 3'd2;
    localparam logic [2:0] BL_8    = 3'd3;
    localparam logic [2:0] BL_16   = 3'd4;
    localparam logic [2:0] BL_32   = 3'd5;
    localparam logic [2:0] BL_64   = 3'd6;
    localparam logic [2:0] BL_PAGE = 3'd7;

    localparam logic ADDR_SEQ = 1'b0;
    localparam logic ADDR_LIN = 1'b1;

    localparam int unsigned BEAT_CNT_W = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Wrap mask for a burst code; full page leaves every bit free to carry.
    function automatic logic [31:0] burst_mask(input logic [2:0] bl);
        if (bl == BL_PAGE) begin
            return '1;
        end
        return (32'd1 << bl) - 32'd1;
    endfunction

    // Index of the final counted beat (meaningless for full page).
    function automatic logic [BEAT_CNT_W-1:0] burst_last_idx(input logic [2:0] bl);
        return BEAT_CNT_W'((BEAT_CNT_W'(1) << bl) - BEAT_CNT_W'(1));
    endfunction

endpackage

// File: rtl/burst_col_incr.sv
// Masked column incrementer: bits under the mask count, bits outside it hold.
module burst_col_incr #(
    parameter int unsigned COL_W = 8
) (
    input  logic [COL_W-1:0] i_col,
    input  logic [COL_W-1:0] i_mask,
    output logic [COL_W-1:0] o_next
);

    logic [COL_W-1:0] w_inc;

    assign w_inc  = i_col + COL_W'(1);
    assign o_next = (i_col & ~i_mask) | (w_inc & i_mask);

endmodule

// File: rtl/burst_col_sequencer.sv
// SDRAM burst column sequencer: one column address per cycle with sequential wrap or linear run.
// Optional BURST_INTERRUPT_EN lets a new command abort a burst in progress.
module burst_col_sequencer
    import sdram_burst_pkg::*;
#(
    parameter int unsigned COL_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic             CmdWrite,
    input  logic [COL_W-1:0] StartCol,
    input  logic             AddrMode,
    input  logic [2:0]       BurstLength,
    input  logic             Terminate,
    output logic             ColValid,
    output logic [COL_W-1:0] ColAddr,
    output logic             ColWrite,
    output logic             BurstLast,
    output logic             Busy
);

    state_t                r_state, w_state_nxt;
    logic [COL_W-1:0]      r_col_addr, w_col_addr_nxt;
    logic                  r_col_valid, w_col_valid_nxt;
    logic                  r_col_write, w_col_write_nxt;
    logic                  r_burst_last, w_burst_last_nxt;
    logic                  r_mode, w_mode_nxt;
    logic [2:0]            r_bl, w_bl_nxt;
    logic [BEAT_CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [BEAT_CNT_W-1:0] w_cnt_inc;
    logic [COL_W-1:0]      w_mask;
    logic [COL_W-1:0]      w_col_next;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_final;

    assign w_mask    = (r_mode == ADDR_LIN) ? '1 : COL_W'(burst_mask(r_bl));
    assign w_cnt_inc = r_cnt + BEAT_CNT_W'(1);

    burst_col_incr #(.COL_W(COL_W)) u_incr (
        .i_col  (r_col_addr),
        .i_mask (w_mask),
        .o_next (w_col_next)
    );

`ifdef BURST_INTERRUPT_EN
    assign w_ready = 1'b1;
`else
    assign w_ready = (r_state == ST_IDLE) | (r_col_valid & r_burst_last);
`endif

    assign CmdReady = w_ready & ~Reset;
    assign w_accept = CmdValid & CmdReady;
    assign w_final  = r_col_valid & (r_burst_last | Terminate);

    // Next-state and next-output logic; an accept always takes priority.
    always_comb begin
        w_state_nxt      = r_state;
        w_col_addr_nxt   = r_col_addr;
        w_col_valid_nxt  = r_col_valid;
        w_col_write_nxt  = r_col_write;
        w_burst_last_nxt = r_burst_last;
        w_mode_nxt       = r_mode;
        w_bl_nxt         = r_bl;
        w_cnt_nxt        = r_cnt;

        if (w_accept) begin
            w_state_nxt      = ST_BURST;
            w_col_addr_nxt   = StartCol;
            w_col_valid_nxt  = 1'b1;
            w_col_write_nxt  = CmdWrite;
            w_burst_last_nxt = (BurstLength == BL_1);
            w_mode_nxt       = AddrMode;
            w_bl_nxt         = BurstLength;
            w_cnt_nxt        = '0;
        end else if (r_state == ST_BURST) begin
            if (w_final) begin
                w_state_nxt      = ST_IDLE;
                w_col_valid_nxt  = 1'b0;
                w_burst_last_nxt = 1'b0;
            end else begin
                w_col_addr_nxt   = w_col_next;
                w_cnt_nxt        = w_cnt_inc;
                w_burst_last_nxt = (r_bl != BL_PAGE) && (w_cnt_inc == burst_last_idx(r_bl));
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_col_addr   <= '0;
            r_col_valid  <= 1'b0;
            r_col_write  <= 1'b0;
            r_burst_last <= 1'b0;
            r_mode       <= 1'b0;
            r_bl         <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_col_addr   <= w_col_addr_nxt;
            r_col_valid  <= w_col_valid_nxt;
            r_col_write  <= w_col_write_nxt;
            r_burst_last <= w_burst_last_nxt;
            r_mode       <= w_mode_nxt;
            r_bl         <= w_bl_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign ColValid  = r_col_valid;
    assign ColAddr   = r_col_addr;
    assign ColWrite  = r_col_write;
    assign BurstLast = r_burst_last;
    assign Busy      = (r_state == ST_BURST);

endmodule

// File: tb/tb_burst_col_sequencer.sv
// Bench for burst_col_sequencer: directed vector table, hand corner sequences, random vs reference model.
module tb_burst_col_sequencer;

    logic       Clk;
    logic       Reset;
    logic       CmdValid;
    logic       CmdReady;
    logic       CmdWrite;
    logic [7:0] StartCol;
    logic       AddrMode;
    logic [2:0] BurstLength;
    logic       Terminate;
    logic       ColValid;
    logic [7:0] ColAddr;
    logic       ColWrite;
    logic       BurstLast;
    logic       Busy;

    int n_vec = 0;
    int n_err = 0;

    burst_col_sequencer #(.COL_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdWrite(CmdWrite), .StartCol(StartCol), .AddrMode(AddrMode),
        .BurstLength(BurstLength), .Terminate(Terminate), .ColValid(ColValid),
        .ColAddr(ColAddr), .ColWrite(ColWrite), .BurstLast(BurstLast), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: burst described by its start column and beat index.
    bit       m_active;
    bit       m_write;
    bit       m_mode;
    bit [2:0] m_bl;
    bit [7:0] m_start;
    bit [7:0] m_addr;
    int       m_k;

    function automatic bit [7:0] exp_col(bit [7:0] s, bit mode, bit [2:0] bl, int k);
        bit [7:0] msk;
        bit [7:0] sum;
        msk = (mode || bl == 3'd7) ? 8'hFF : 8'((1 << bl) - 1);
        sum = s + 8'(k);
        return (s & ~msk) | (sum & msk);
    endfunction

    function automatic bit m_last();
        return m_active && (m_bl != 3'd7) && (m_k == (1 << m_bl) - 1);
    endfunction

    function automatic bit m_ready();
`ifdef BURST_INTERRUPT_EN
        return 1'b1;
`else
        return !m_active || m_last();
`endif
    endfunction

    task automatic model_reset();
        m_active = 0; m_write = 0; m_mode = 0; m_bl = 0; m_start = 0; m_addr = 0; m_k = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(ColValid), 32'(m_active));
        chk("m_busy", 32'(Busy), 32'(m_active));
        chk("m_last", 32'(BurstLast), 32'(m_last()));
        chk("m_ready", 32'(CmdReady), 32'(m_ready()));
        chk("m_addr", 32'(ColAddr), 32'(m_addr));
        if (m_active) chk("m_write", 32'(ColWrite), 32'(m_write));
    endtask

    // One clock: drive inputs, advance model across the edge, check outputs after it.
    task automatic tick(input bit v, input bit w, input bit [7:0] sc, input bit am,
                        input bit [2:0] bl, input bit term);
        bit lastn;
        bit acc;
        CmdValid = v; CmdWrite = w; StartCol = sc; AddrMode = am; BurstLength = bl; Terminate = term;
        lastn = m_last();
        acc   = v && m_ready();
        @(posedge Clk);
        if (acc) begin
            m_active = 1; m_write = w; m_mode = am; m_bl = bl; m_start = sc; m_k = 0;
        end else if (m_active) begin
            if (lastn || term) m_active = 0;
            else m_k++;
        end
        if (m_active) m_addr = exp_col(m_start, m_mode, m_bl, m_k);
        #1;
        check_model();
    endtask

    task automatic idle();
        tick(0, 0, 8'h00, 0, 3'd0, 0);
    endtask

    typedef struct {
        bit       v;
        bit       w;
        bit [7:0] sc;
        bit       am;
        bit [2:0] bl;
        bit       term;
        bit       e_valid;
        bit [7:0] e_addr;
        bit       e_last;
        bit       e_write;
    } vec_t;

    function automatic vec_t mk(bit v, bit w, bit [7:0] sc, bit am, bit [2:0] bl,
                                bit ev, bit [7:0] ea, bit el, bit ew);
        vec_t r;
        r.v = v; r.w = w; r.sc = sc; r.am = am; r.bl = bl; r.term = 0;
        r.e_valid = ev; r.e_addr = ea; r.e_last = el; r.e_write = ew;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        bit [7:0] lin_seq [8];
        CmdValid = 0; CmdWrite = 0; StartCol = 0; AddrMode = 0; BurstLength = 0; Terminate = 0;
        model_reset();

        // Sequential BL=2 from 0x06, read.
        tbl.push_back(mk(1, 0, 8'h06, 0, 3'd2, 1, 8'h06, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 1, 8'h07, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 1, 8'h04, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 1, 8'h05, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 0, 8'h05, 0, 0));
        // Linear BL=3 from 0xFD, write, rolling over the page end.
        lin_seq = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        tbl.push_back(mk(1, 1, 8'hFD, 1, 3'd3, 1, lin_seq[0], 0, 1));
        for (int i = 1; i < 8; i++)
            tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 1, lin_seq[i], i == 7, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 0, 8'h04, 0, 0));
        // Back-to-back: BL=1 at 0x20, BL=0 at 0x40 accepted on the last beat.
        tbl.push_back(mk(1, 0, 8'h20, 0, 3'd1, 1, 8'h20, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 1, 8'h21, 1, 0));
        tbl.push_back(mk(1, 0, 8'h40, 0, 3'd0, 1, 8'h40, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 3'd0, 0, 8'h40, 0, 0));

        // Reset state.
        Reset = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        chk("rst_valid", 32'(ColValid), 0);
        chk("rst_addr", 32'(ColAddr), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_last", 32'(BurstLast), 0);
        Reset = 1'b0;
        #1;
        chk("rst_ready", 32'(CmdReady), 1);

        // Directed vector table.
        foreach (tbl[i]) begin
            tick(tbl[i].v, tbl[i].w, tbl[i].sc, tbl[i].am, tbl[i].bl, tbl[i].term);
            chk($sformatf("tbl%0d_valid", i), 32'(ColValid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_busy", i), 32'(Busy), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_addr", i), 32'(ColAddr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_last", i), 32'(BurstLast), 32'(tbl[i].e_last));
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_write", i), 32'(ColWrite), 32'(tbl[i].e_write));
        end

        // Asynchronous reset on beat 4 of a BL=3 write burst.
        tick(1, 1, 8'h13, 0, 3'd3, 0);
        idle(); idle(); idle();
        chk("pre_rst_addr", 32'(ColAddr), 32'h16);
        #2 Reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ColValid), 0);
        chk("arst_addr", 32'(ColAddr), 0);
        chk("arst_write", 32'(ColWrite), 0);
        chk("arst_last", 32'(BurstLast), 0);
        chk("arst_busy", 32'(Busy), 0);
        chk("arst_ready", 32'(CmdReady), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
        #1;
        chk("arst_rel_ready", 32'(CmdReady), 1);
        chk("arst_rel_valid", 32'(ColValid), 0);

        // Full page from 0x10, terminated while beat 300 is on the bus.
        tick(1, 0, 8'h10, 0, 3'd7, 0);
        for (int i = 1; i < 300; i++) begin
            idle();
            if (i == 239) chk("page_ff", 32'(ColAddr), 32'hFF);
            if (i == 240) chk("page_wrap", 32'(ColAddr), 32'h00);
        end
        chk("page_beat300", 32'(ColAddr), 32'h3B);
        chk("page_still_valid", 32'(ColValid), 1);
        tick(0, 0, 8'h00, 0, 3'd0, 1);
        chk("page_term_valid", 32'(ColValid), 0);
        chk("page_term_hold", 32'(ColAddr), 32'h3B);
        tick(0, 0, 8'h00, 0, 3'd0, 1);
        chk("idle_term_ignored", 32'(ColValid), 0);

`ifdef BURST_INTERRUPT_EN
        // Interrupting command at beat 2, then accept colliding with Terminate.
        tick(1, 0, 8'h00, 0, 3'd3, 0);
        idle(); idle();
        chk("int_beat2", 32'(ColAddr), 32'h02);
        tick(1, 0, 8'h80, 0, 3'd3, 0);
        chk("int_new", 32'(ColAddr), 32'h80);
        idle();
        chk("int_next", 32'(ColAddr), 32'h81);
        tick(1, 1, 8'hC0, 1, 3'd2, 1);
        chk("int_acc_wins_valid", 32'(ColValid), 1);
        chk("int_acc_wins_addr", 32'(ColAddr), 32'hC0);
`else
        // Command offered mid-burst must wait for the last beat.
        tick(1, 0, 8'h00, 0, 3'd3, 0);
        tick(1, 0, 8'h80, 0, 3'd3, 0);
        chk("noint_hold", 32'(ColAddr), 32'h01);
`endif
        for (int i = 0; i < 300 && m_active; i++) idle();

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bit [2:0] rbl;
            rbl = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            tick($urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom), 1'($urandom),
                 rbl, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 300 && m_active; i++) tick(0, 0, 8'h00, 0, 3'd0, 1);
        chk("final_idle", 32'(Busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
